cmd_executor: RTL and testbench

- Execution back-end for the testbench command path: sits downstream of the command decoder and upstream of the sequencer's `ack` input.
- Takes one decoded SET / WAIT / CHECK command at a time and acts on it:
  - SET drives a stimulus bus.
  - WAIT watches an event line, with an optional timeout.
  - CHECK compares an observed bus against an expected value.
- After every command it returns a single-cycle acknowledge with a status, which is what lets the sequencer advance to its next command.

---
 rtl/cmd_executor.sv | 195 +++++++++++++++++++
 tb/tb_cmd_executor.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_executor.sv
// cmd_executor: runs one decoded SET / WAIT / CHECK command at a time
// and answers each with a single-cycle ack carrying a status code.
module cmd_executor #(
   parameter int                 G_NB_IO     = 16,
   parameter int                 G_NB_EVENT  = 8,
   parameter int                 G_TIMEOUT_W = 32,
   parameter logic [G_NB_IO-1:0] G_SET_RST   = '0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_sel_set,
   input  logic                        i_sel_wait,
   input  logic                        i_sel_check,
   input  logic [$clog2(G_NB_EVENT):0] i_idx,
   input  logic                        i_level,
   input  logic [G_TIMEOUT_W-1:0]      i_timeout,
   input  logic [G_NB_IO-1:0]          i_value,
   input  logic [G_NB_IO-1:0]          i_mask,
   input  logic [G_NB_EVENT-1:0]       i_events,
   input  logic [G_NB_IO-1:0]          i_check_bus,
   output logic [G_NB_IO-1:0]          o_set_bus,
   output logic                        o_busy,
   output logic                        o_ack,
   output logic                        o_err,
   output logic [1:0]                  o_err_code,
   output logic [15:0]                 o_err_cnt,
   output logic                        o_overrun
);

   localparam int                     EW     = $clog2(G_NB_EVENT);
   localparam logic [EW:0]            NB_EV  = (EW+1)'(G_NB_EVENT);
   localparam logic [G_TIMEOUT_W-1:0] TO_ONE = G_TIMEOUT_W'(1);

   localparam logic [1:0] C_OK  = 2'd0;
   localparam logic [1:0] C_TMO = 2'd1;
   localparam logic [1:0] C_MIS = 2'd2;
   localparam logic [1:0] C_ILL = 2'd3;

   // EXEC_ILL holds an illegal command for one cycle so it acks at E1
   typedef enum logic [2:0] {
      IDLE,
      EXEC_SET,
      EXEC_WAIT,
      EXEC_CHECK,
      EXEC_ILL
   } state_t;

   state_t                 state_q, state_d;
   logic [EW-1:0]          idx_q, idx_d;
   logic                   level_q, level_d;
   logic [G_TIMEOUT_W-1:0] tmo_q, tmo_d;
   logic [G_NB_IO-1:0]     value_q, value_d;
   logic [G_NB_IO-1:0]     mask_q, mask_d;
   logic [G_TIMEOUT_W-1:0] cnt_q, cnt_d;
   logic [G_NB_IO-1:0]     set_q, set_d;
   logic                   busy_q, busy_d;
   logic                   ack_q, ack_d;
   logic                   err_q, err_d;
   logic [1:0]             code_q, code_d;
   logic [15:0]            errcnt_q, errcnt_d;
   logic                   ovr_q, ovr_d;

   logic [2:0]             sel;
   logic                   done;
   logic [1:0]             code;

   assign sel = {i_sel_set, i_sel_wait, i_sel_check};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         level_q  <= 1'b0;
         tmo_q    <= '0;
         value_q  <= '0;
         mask_q   <= '0;
         cnt_q    <= '0;
         set_q    <= G_SET_RST;
         busy_q   <= 1'b0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         code_q   <= C_OK;
         errcnt_q <= '0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         level_q  <= level_d;
         tmo_q    <= tmo_d;
         value_q  <= value_d;
         mask_q   <= mask_d;
         cnt_q    <= cnt_d;
         set_q    <= set_d;
         busy_q   <= busy_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         code_q   <= code_d;
         errcnt_q <= errcnt_d;
         ovr_q    <= ovr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      level_d  = level_q;
      tmo_d    = tmo_q;
      value_d  = value_q;
      mask_d   = mask_q;
      cnt_d    = cnt_q;
      set_d    = set_q;
      busy_d   = busy_q;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      code_d   = C_OK;
      errcnt_d = errcnt_q;
      ovr_d    = ovr_q;
      done     = 1'b0;
      code     = C_OK;

      if (busy_q && (sel != 3'b000)) begin
         ovr_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (sel != 3'b000) begin
               idx_d   = i_idx[EW-1:0];
               level_d = i_level;
               tmo_d   = i_timeout;
               value_d = i_value;
               mask_d  = i_mask;
               cnt_d   = '0;
               busy_d  = 1'b1;
               unique case (sel)
                  3'b100:  state_d = EXEC_SET;
                  3'b010:  state_d = (i_idx >= NB_EV) ? EXEC_ILL
                                                      : EXEC_WAIT;
                  3'b001:  state_d = EXEC_CHECK;
                  default: state_d = EXEC_ILL;
               endcase
            end
         end
         EXEC_SET: begin
            set_d = (set_q & ~mask_q) | (value_q & mask_q);
            done  = 1'b1;
         end
         EXEC_CHECK: begin
            done = 1'b1;
            if (((i_check_bus ^ value_q) & mask_q) != '0) begin
               code = C_MIS;
            end
         end
         EXEC_WAIT: begin
            // a matching event beats a timeout landing on the same edge
            if (i_events[idx_q] == level_q) begin
               done = 1'b1;
            end else if ((tmo_q != '0) && (cnt_q == tmo_q - TO_ONE)) begin
               done = 1'b1;
               code = C_TMO;
            end else begin
               cnt_d = cnt_q + TO_ONE;
            end
         end
         EXEC_ILL: begin
            done = 1'b1;
            code = C_ILL;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase

      if (done) begin
         state_d = IDLE;
         busy_d  = 1'b0;
         ack_d   = 1'b1;
         code_d  = code;
         err_d   = (code != C_OK);
         if (err_d && (errcnt_q != 16'hFFFF)) begin
            errcnt_d = errcnt_q + 16'd1;
         end
      end
   end

   assign o_set_bus  = set_q;
   assign o_busy     = busy_q;
   assign o_ack      = ack_q;
   assign o_err      = err_q;
   assign o_err_code = code_q;
   assign o_err_cnt  = errcnt_q;
   assign o_overrun  = ovr_q;

endmodule

// File: tb/tb_cmd_executor.sv
// tb_cmd_executor: directed and random commands against a cycle-level
// reference model of the command executor.
module tb_cmd_executor;

   localparam int NB  = 16;
   localparam int NE  = 8;
   localparam int TW  = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_sel_set = 1'b0;
   logic          i_sel_wait = 1'b0;
   logic          i_sel_check = 1'b0;
   logic [3:0]    i_idx = '0;
   logic          i_level = 1'b0;
   logic [TW-1:0] i_timeout = '0;
   logic [NB-1:0] i_value = '0;
   logic [NB-1:0] i_mask = '0;
   logic [NE-1:0] i_events = '0;
   logic [NB-1:0] i_check_bus = '0;
   logic [NB-1:0] o_set_bus;
   logic          o_busy;
   logic          o_ack;
   logic          o_err;
   logic [1:0]    o_err_code;
   logic [15:0]   o_err_cnt;
   logic          o_overrun;

   int checks = 0;
   int errors = 0;

   cmd_executor #(
      .G_NB_IO     (NB),
      .G_NB_EVENT  (NE),
      .G_TIMEOUT_W (TW),
      .G_SET_RST   (16'h0000)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_sel_set   (i_sel_set),
      .i_sel_wait  (i_sel_wait),
      .i_sel_check (i_sel_check),
      .i_idx       (i_idx),
      .i_level     (i_level),
      .i_timeout   (i_timeout),
      .i_value     (i_value),
      .i_mask      (i_mask),
      .i_events    (i_events),
      .i_check_bus (i_check_bus),
      .o_set_bus   (o_set_bus),
      .o_busy      (o_busy),
      .o_ack       (o_ack),
      .o_err       (o_err),
      .o_err_code  (o_err_code),
      .o_err_cnt   (o_err_cnt),
      .o_overrun   (o_overrun)
   );

   always #5 clk = ~clk;

   // Reference model: a pending command plus cycles elapsed since accept
   typedef enum int {K_SET, K_WAIT, K_CHK, K_ILL} kind_t;

   logic [NB-1:0] m_set = '0;
   bit            m_busy = 0;
   bit            m_ack = 0;
   bit            m_err = 0;
   int            m_code = 0;
   int            m_cnt = 0;
   bit            m_ovr = 0;
   kind_t         m_kind = K_SET;
   int            m_n = 0;
   int            m_idx = 0;
   bit            m_lvl = 0;
   longint        m_to = 0;
   logic [NB-1:0] m_val = '0;
   logic [NB-1:0] m_msk = '0;

   always @(posedge clk or posedge rst) begin
      int nsel;
      bit fin;
      int c;
      if (rst) begin
         m_set = '0; m_busy = 0; m_ack = 0; m_err = 0;
         m_code = 0; m_cnt = 0; m_ovr = 0; m_n = 0;
      end else begin
         nsel = int'(i_sel_set) + int'(i_sel_wait) + int'(i_sel_check);
         m_ack = 0; m_err = 0; m_code = 0;
         if (m_busy) begin
            if (nsel != 0) m_ovr = 1;
            m_n++;
            fin = 0;
            c = 0;
            case (m_kind)
               K_SET: begin
                  m_set = (m_set & ~m_msk) | (m_val & m_msk);
                  fin = 1;
               end
               K_CHK: begin
                  fin = 1;
                  if ((i_check_bus & m_msk) != (m_val & m_msk)) c = 2;
               end
               K_ILL: begin
                  fin = 1;
                  c = 3;
               end
               K_WAIT: begin
                  if (i_events[m_idx] == m_lvl) fin = 1;
                  else if (m_to != 0 && m_n == m_to) begin
                     fin = 1;
                     c = 1;
                  end
               end
               default: ;
            endcase
            if (fin) begin
               m_busy = 0;
               m_ack = 1;
               m_code = c;
               m_err = (c != 0);
               if (m_err && m_cnt < 65535) m_cnt++;
            end
         end else if (nsel != 0) begin
            m_busy = 1;
            m_n = 0;
            m_idx = int'(i_idx);
            m_lvl = i_level;
            m_to = longint'(i_timeout);
            m_val = i_value;
            m_msk = i_mask;
            if (nsel > 1) m_kind = K_ILL;
            else if (i_sel_set) m_kind = K_SET;
            else if (i_sel_check) m_kind = K_CHK;
            else if (int'(i_idx) >= NE) m_kind = K_ILL;
            else m_kind = K_WAIT;
         end
      end
   end

   always @(negedge clk) begin
      checks++;
      if (o_set_bus !== m_set || o_busy !== m_busy || o_ack !== m_ack ||
          o_err !== m_err || int'(o_err_code) != m_code ||
          int'(o_err_cnt) != m_cnt || o_overrun !== m_ovr) begin
         errors++;
         $display("FAIL model_cmp t=%0t got bus=%h busy=%b ack=%b err=%b code=%0d cnt=%0d ovr=%b want bus=%h busy=%b ack=%b err=%b code=%0d cnt=%0d ovr=%b",
                  $time, o_set_bus, o_busy, o_ack, o_err, o_err_code,
                  o_err_cnt, o_overrun, m_set, m_busy, m_ack, m_err,
                  m_code, m_cnt, m_ovr);
      end
   end

   task automatic lit(input string name, input longint act,
                      input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic fields(input int idx, input bit lvl, input int to,
                         input logic [NB-1:0] val,
                         input logic [NB-1:0] msk);
      i_idx     = 4'(idx);
      i_level   = lvl;
      i_timeout = TW'(to);
      i_value   = val;
      i_mask    = msk;
   endtask

   // Called on a negedge; returns on the negedge where o_ack is seen.
   // lat is the n of the acking edge E_n; rise=n raises the event for E_n.
   task automatic run(input logic [2:0] sel, input int rise,
                      input int ovr_at, input bit rnd, output int lat);
      {i_sel_set, i_sel_wait, i_sel_check} = sel;
      lat = -1;
      for (int i = 1; i <= 3000; i++) begin
         @(negedge clk);
         if (o_ack) begin
            lat = i - 1;
            break;
         end
         {i_sel_set, i_sel_wait, i_sel_check} = 3'b000;
         if (i == ovr_at) i_sel_set = 1'b1;
         if (i == rise) i_events[i_idx[2:0]] = i_level;
         if (rnd) i_events = NE'($urandom);
      end
      if (lat < 0) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout got no ack want ack within 3000");
         rst = 1'b1;
         @(negedge clk);
         @(negedge clk);
         rst = 1'b0;
      end
   endtask

   initial begin
      int lat;
      int r;

      @(negedge clk);
      @(negedge clk);
      lit("rst_bus", o_set_bus, 0);
      lit("rst_ack", o_ack, 0);
      rst = 1'b0;
      @(negedge clk);

      fields(0, 0, 0, 16'h00FF, 16'h0F0F);
      run(3'b100, 0, 0, 0, lat);
      lit("set_lat", lat, 1);
      lit("set_bus", o_set_bus, 16'h000F);
      lit("set_code", o_err_code, 0);
      @(negedge clk);
      lit("ack_one_cycle", o_ack, 0);

      fields(3, 1, 10, '0, '0);
      run(3'b010, 4, 0, 0, lat);
      lit("wait_lat", lat, 4);
      lit("wait_code", o_err_code, 0);
      i_events = '0;

      run(3'b010, 0, 0, 0, lat);
      lit("tmo_lat", lat, 10);
      lit("tmo_err", o_err, 1);
      lit("tmo_code", o_err_code, 1);
      lit("tmo_cnt", o_err_cnt, 1);

      fields(3, 1, 0, '0, '0);
      run(3'b010, 1000, 0, 0, lat);
      lit("wait0_lat", lat, 1000);
      lit("wait0_code", o_err_code, 0);
      i_events = '0;

      fields(3, 1, 10, '0, '0);
      run(3'b010, 10, 0, 0, lat);
      lit("tie_lat", lat, 10);
      lit("tie_code", o_err_code, 0);
      i_events = '0;

      fields(0, 0, 0, 16'hA5A5, 16'hFF00);
      i_check_bus = 16'hA512;
      run(3'b001, 0, 0, 0, lat);
      lit("chk_ok_code", o_err_code, 0);
      i_check_bus = 16'hB5A5;
      run(3'b001, 0, 0, 0, lat);
      lit("chk_bad_err", o_err, 1);
      lit("chk_bad_code", o_err_code, 2);

      fields(0, 0, 0, 16'hFFFF, 16'hFFFF);
      run(3'b101, 0, 0, 0, lat);
      lit("ill_lat", lat, 1);
      lit("ill_code", o_err_code, 3);
      lit("ill_bus", o_set_bus, 16'h000F);

      fields(8, 1, 5, '0, '0);
      run(3'b010, 0, 0, 0, lat);
      lit("ill_idx_code", o_err_code, 3);
      lit("ill_idx_cnt", o_err_cnt, 4);

      fields(0, 0, 0, 16'hF000, 16'hF000);
      run(3'b100, 0, 0, 0, lat);
      lit("b2b_lat0", lat, 1);
      lit("b2b_bus0", o_set_bus, 16'hF00F);
      fields(0, 0, 0, 16'h0000, 16'h000F);
      run(3'b100, 0, 0, 0, lat);
      lit("b2b_lat1", lat, 1);
      lit("b2b_bus1", o_set_bus, 16'hF000);
      lit("b2b_no_ovr", o_overrun, 0);

      fields(2, 1, 0, 16'h1234, 16'hFFFF);
      run(3'b010, 6, 3, 0, lat);
      lit("ovr_lat", lat, 6);
      lit("ovr_code", o_err_code, 0);
      lit("ovr_flag", o_overrun, 1);
      lit("ovr_bus", o_set_bus, 16'hF000);
      i_events = '0;

      fields(5, 1, 0, '0, '0);
      i_sel_wait = 1'b1;
      @(negedge clk);
      i_sel_wait = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      lit("rst_mid_busy", o_busy, 0);
      lit("rst_mid_bus", o_set_bus, 0);
      lit("rst_mid_ovr", o_overrun, 0);
      lit("rst_mid_cnt", o_err_cnt, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int k = 0; k < 400; k++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         fields($urandom_range(0, 7), 1'($urandom), $urandom_range(0, 12),
                NB'($urandom), NB'($urandom));
         i_check_bus = ($urandom_range(0, 1) == 1) ? i_value
                                                   : NB'($urandom);
         r = $urandom_range(0, 9);
         if (r == 9) i_idx = 4'd8 + 4'($urandom_range(0, 7));
         case (r)
            0, 1, 2: run(3'b100, 0, 0, 1, lat);
            3, 4, 5, 9: run(3'b010, 0, 0, 1, lat);
            6, 7: run(3'b001, 0, 0, 1, lat);
            default: run(3'b110, 0, 0, 1, lat);
         endcase
      end
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
